fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side drain stage that sits directly downstream of the asynchronous FIFO's read port, in the rclk domain.
//  Converts the FIFO's r_en/empty/registered-data_out interface into a valid/ready stream.
//  Uses a small prefetch buffer so it sustains 1 word/cycle.
//  There is no combinational path from m_ready to fifo_r_en.
// PARAMETERS
//  DATA_WIDTH  8  word width; must equal the FIFO DATA_WIDTH
//  BUF_DEPTH   3  prefetch entries; must be >=3 for full throughput
//  CNT_WIDTH  16  width of the delivered-word counter
// PORTS
//  rclk        in   1                         read-domain clock (single clock)
//  rrst        in   1                         synchronous, active-high reset
//  fifo_empty  in   1                         FIFO empty flag (registered in FIFO)
//  fifo_data   in   DATA_WIDTH                FIFO data_out; valid the cycle after an accepted read
//  fifo_r_en   out  1                         read request to FIFO
//  flush       in   1                         synchronous discard of buffered and in-flight words
//  m_valid     out  1                         output word valid
//  m_ready     in   1                         downstream accepts
//  m_data      out  DATA_WIDTH                output word (head of buffer)
//  occupancy   out  $clog2(BUF_DEPTH+1)       words held in buffer
//  word_cnt    out  CNT_WIDTH                 words delivered (m_valid&&m_ready), wraps mod 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (rrst=1 at edge):
//   - buffer cleared, inflight=0, word_cnt=0
//   - m_valid=0, m_data=0, occupancy=0
//   - fifo_r_en=0 for the whole cycle rrst is high
//  Read issue (combinational from registered state + fifo_empty):
//   - fifo_r_en = !rrst && !flush && !fifo_empty && (occupancy + inflight < BUF_DEPTH)
//  Accepted read:
//   - inflight<=1 at the edge where fifo_r_en=1; else inflight<=0
//   - fifo_data is captured into the buffer tail at the next edge when inflight=1
//  Latency: buffer empty, FIFO non-empty in cycle 0 -> fifo_r_en=1 in cycle 0 -> m_valid=1 in cycle 2.
//  Output:
//   - m_valid = (occupancy!=0) && !flush; m_data = head entry (0 when empty)
//   - while m_valid && !m_ready, m_valid and m_data hold stable
//  Simultaneous events:
//   - capture and pop in the same cycle: occupancy unchanged, order preserved
//   - capture into an empty buffer while popping is not possible (m_valid=0)
//  Full buffer: occupancy+inflight==BUF_DEPTH -> fifo_r_en=0. Overflow is impossible by construction.
//  Throughput: with m_ready=1 and the FIFO continuously non-empty, steady state is occupancy=1, inflight=1, 1 word/cycle.
//  Flush (one cycle):
//   - fifo_r_en=0 and m_valid=0 that cycle
//   - next edge: buffer emptied, inflight cleared, and a word arriving on fifo_data that edge is discarded
//   - word_cnt is not cleared
//   - words already popped from the FIFO are lost by design
//  Reset mid-operation: the in-flight word is dropped. rrst must be applied together with the FIFO's read-domain reset.
//  Pointer arithmetic: buffer read/write indices wrap at BUF_DEPTH, which need not be a power of 2.
// STRUCTURE
//  - Package afifo_pkg: default DATA_WIDTH/depth constants shared with the async FIFO, plus the occupancy width localparam.
//  - One sub-module, rd_prefetch_buf: a BUF_DEPTH-entry register FIFO with push/pop/clear and occupancy.
//    Issue/inflight/flush/count logic stays in fifo_rd_stream.
// TESTING
//  1. Single word: FIFO holds 0xA5, m_ready=1 -> fifo_r_en 1 cycle, m_valid in cycle 2 with m_data=0xA5, word_cnt=1.
//  2. Streaming: 20 words 0..19, m_ready=1 -> after initial 2-cycle latency, one word/cycle in order; word_cnt=20.
//  3. Backpressure: m_ready=0 for 10 cycles -> occupancy stops at 3, fifo_r_en=0, m_data stable.
//     Release -> words delivered in order, none lost or duplicated.
//  4. Flush while inflight=1 and occupancy=2 -> next cycle occupancy=0, m_valid=0, and the arriving word is not delivered.
//     Fetching resumes the following cycle.
//  5. rrst asserted mid-stream -> next cycle all outputs 0 and fifo_r_en=0 during reset.
//  6. word_cnt wrap: with CNT_WIDTH=4, deliver 17 words -> word_cnt=1.

Source files
------------

// File: rtl/afifo_pkg.sv
// afifo_pkg: defaults shared with the async FIFO and width helpers for the read-side stream stage.
package afifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUF_DEPTH_DEF  = 3;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int OCC_WIDTH_DEF  = $clog2(BUF_DEPTH_DEF + 1);
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream of the drain stage.
interface fifo_rd_stream_if
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    modport master (input fifo_empty, fifo_data, m_ready, output fifo_r_en, m_valid, m_data);
    modport slave  (output fifo_empty, fifo_data, m_ready, input fifo_r_en, m_valid, m_data);
endinterface

// File: rtl/rd_prefetch_buf.sv
// rd_prefetch_buf: small register FIFO with push/pop/clear; indices wrap at BUF_DEPTH (any depth).
module rd_prefetch_buf
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int OCC_WIDTH  = occ_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [OCC_WIDTH-1:0]  o_occ
);
    localparam int IW = idx_width(BUF_DEPTH);
    localparam logic [IW-1:0] LAST = IW'(BUF_DEPTH - 1);
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [IW-1:0]         r_wr;
    logic [IW-1:0]         r_rd;
    logic [OCC_WIDTH-1:0]  r_occ;
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (i_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + IW'(1);
            if (i_pop) r_rd <= (r_rd == LAST) ? '0 : r_rd + IW'(1);
            r_occ <= r_occ + OCC_WIDTH'(i_push) - OCC_WIDTH'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !i_clear && !rst) r_mem[r_wr] <= i_data;
    end
    assign o_data = (r_occ != '0) ? r_mem[r_rd] : '0;
    assign o_occ  = r_occ;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a valid/ready stream at 1 word/cycle.
// Read issue depends only on registered state and fifo_empty, never on m_ready.
module fifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int OCC_WIDTH  = occ_width(BUF_DEPTH)
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [OCC_WIDTH-1:0] occupancy,
    output logic [CNT_WIDTH-1:0] word_cnt
);
    localparam logic [OCC_WIDTH:0] DEPTH_W = (OCC_WIDTH + 1)'(BUF_DEPTH);
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  w_pop;
    logic [OCC_WIDTH:0]    w_pending;
    logic [DATA_WIDTH-1:0] w_head;
    // Counting the in-flight word keeps the buffer from ever overflowing.
    assign w_pending     = {1'b0, occupancy} + {{OCC_WIDTH{1'b0}}, r_inflight};
    assign bus.fifo_r_en = !rrst && !flush && !bus.fifo_empty && (w_pending < DEPTH_W);
    assign bus.m_valid   = (occupancy != '0) && !flush;
    assign bus.m_data    = w_head;
    assign w_pop         = bus.m_valid && bus.m_ready;
    assign word_cnt      = r_word_cnt;
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_inflight <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= bus.fifo_r_en;
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(w_pop);
        end
    end
    rd_prefetch_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .OCC_WIDTH (OCC_WIDTH)
    ) u_buf (
        .clk    (rclk),
        .rst    (rrst),
        .i_clear(flush),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_data (bus.fifo_data),
        .o_data (w_head),
        .o_occ  (occupancy)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO read-port model feeding a scoreboard, plus table-driven and corner-case checks.
module tb_fifo_rd_stream;
    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occ;
    logic [1:0] occ4;
    logic [15:0] wcnt;
    logic [3:0]  wcnt4;
    int checks;
    int errors;
    int delivered;
    logic en;
    logic prev_hold;
    logic [7:0] prev_data;
    logic [7:0] src[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       ren0;
        logic       valid2;
        int         cnt;
    } vec_t;
    vec_t vecs[4];

    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus ();
    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus4 ();
    assign bus4.fifo_empty = bus.fifo_empty;
    assign bus4.fifo_data  = bus.fifo_data;
    assign bus4.m_ready    = bus.m_ready;

    fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) dut (
        .rclk(clk), .rrst(rst), .flush(flush), .bus(bus), .occupancy(occ), .word_cnt(wcnt)
    );
    fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut4 (
        .rclk(clk), .rrst(rst), .flush(flush), .bus(bus4), .occupancy(occ4), .word_cnt(wcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        en = bus.fifo_r_en;
        if (prev_hold && !flush && !rst) begin
            chk("hold_valid", 32'(bus.m_valid), 1);
            chk("hold_data", 32'(bus.m_data), 32'(prev_data));
        end
        prev_hold = bus.m_valid && !bus.m_ready && !flush && !rst;
        prev_data = bus.m_data;
        if (bus.m_valid && bus.m_ready && !rst) begin
            delivered++;
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst || flush) exp_q.delete();
        if (en) begin
            bus.fifo_data = src.pop_front();
            exp_q.push_back(bus.fifo_data);
        end
        bus.fifo_empty = (src.size() == 0);
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) src.push_back(base + 8'(i));
        bus.fifo_empty = (src.size() == 0);
    endtask

    initial begin
        checks = 0; errors = 0; delivered = 0; en = 0; prev_hold = 0; prev_data = 0;
        rst = 1; flush = 0;
        bus.m_ready = 0; bus.fifo_empty = 1; bus.fifo_data = 0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 2};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 3};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 4};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 5};

        load(1, 8'h11);
        sample();
        chk("rst_ren", 32'(en), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_data", 32'(bus.m_data), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_cnt", 32'(wcnt), 0);
        advance();
        rst = 0;
        bus.m_ready = 1;
        sample();
        chk("post_rst_ren", 32'(en), 1);
        advance();
        repeat (5) cyc();
        chk("post_rst_cnt", 32'(wcnt), 1);

        foreach (vecs[v]) begin
            load(1, vecs[v].data);
            sample();
            chk("vec_ren0", 32'(en), 32'(vecs[v].ren0));
            chk("vec_valid0", 32'(bus.m_valid), 0);
            advance();
            sample();
            chk("vec_ren1", 32'(en), 0);
            chk("vec_valid1", 32'(bus.m_valid), 0);
            advance();
            sample();
            chk("vec_valid2", 32'(bus.m_valid), 32'(vecs[v].valid2));
            chk("vec_data2", 32'(bus.m_data), 32'(vecs[v].data));
            chk("vec_occ2", 32'(occ), 1);
            advance();
            sample();
            chk("vec_cnt", 32'(wcnt), 32'(vecs[v].cnt));
            chk("vec_valid3", 32'(bus.m_valid), 0);
            advance();
        end

        load(20, 8'h00);
        sample();
        chk("stream_ren0", 32'(en), 1);
        advance();
        cyc();
        for (int i = 0; i < 20; i++) begin
            sample();
            chk("stream_valid", 32'(bus.m_valid), 1);
            chk("stream_data", 32'(bus.m_data), 32'(i));
            advance();
        end
        repeat (2) cyc();
        chk("stream_cnt", 32'(wcnt), 25);

        bus.m_ready = 0;
        load(10, 8'h40);
        repeat (10) cyc();
        sample();
        chk("bp_occ", 32'(occ), 3);
        chk("bp_ren", 32'(en), 0);
        chk("bp_data", 32'(bus.m_data), 32'h40);
        advance();
        bus.m_ready = 1;
        repeat (20) cyc();
        chk("bp_drained", 32'(exp_q.size()), 0);
        chk("bp_cnt", 32'(wcnt), 35);

        bus.m_ready = 0;
        load(5, 8'h60);
        repeat (3) cyc();
        flush = 1;
        sample();
        chk("fl_occ_before", 32'(occ), 2);
        chk("fl_ren", 32'(en), 0);
        chk("fl_valid", 32'(bus.m_valid), 0);
        advance();
        flush = 0;
        sample();
        chk("fl_occ_after", 32'(occ), 0);
        chk("fl_valid_after", 32'(bus.m_valid), 0);
        chk("fl_resume_ren", 32'(en), 1);
        advance();
        bus.m_ready = 1;
        repeat (10) cyc();
        chk("fl_drained", 32'(exp_q.size()), 0);
        chk("fl_src_empty", 32'(src.size()), 0);
        chk("fl_cnt", 32'(wcnt), 37);

        load(8, 8'h80);
        repeat (4) cyc();
        rst = 1;
        sample();
        chk("mrst_ren0", 32'(en), 0);
        advance();
        sample();
        chk("mrst_ren1", 32'(en), 0);
        chk("mrst_valid", 32'(bus.m_valid), 0);
        chk("mrst_data", 32'(bus.m_data), 0);
        chk("mrst_occ", 32'(occ), 0);
        chk("mrst_cnt", 32'(wcnt), 0);
        advance();
        rst = 0;
        repeat (15) cyc();
        chk("mrst_drained", 32'(exp_q.size()), 0);
        chk("mrst_cnt_after", 32'(wcnt), 4);
        chk("mrst_cnt4_after", 32'(wcnt4), 4);

        rst = 1;
        cyc();
        rst = 0;
        load(17, 8'hC0);
        repeat (25) cyc();
        chk("wrap_drained", 32'(exp_q.size()), 0);
        chk("wrap_cnt16", 32'(wcnt), 17);
        chk("wrap_cnt4", 32'(wcnt4), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
